// File: rtl/memkey_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : memkey_packer                                              |
// | Description : Packs the first 12 bytes of a memcache key big-endian into |
// |               three 32-bit words, counts the full key length (saturating)|
// |               and presents one key block per key with valid/ready.       |
// | Option      : MEMKEY_STATS_EN adds stat_keys / stat_trunc counters.      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module memkey_packer #(
  parameter int LEN_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      k0,
  output logic [31:0]      k1,
  output logic [31:0]      k2,
  output logic [LEN_W-1:0] key_length,
  output logic             trunc
`ifdef MEMKEY_STATS_EN
  ,
  output logic [31:0]      stat_keys,
  output logic [15:0]      stat_trunc
`endif
);

  // INIT only exists so in_ready stays low until the first edge after reset.
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_FILL = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [3:0] idx;        // next byte slot; parks at 12 once the buffer is full
  logic [4:0] lane_lsb;   // LSB of the byte lane inside the target word
  logic       accept;
  logic       handshake;

  assign in_ready  = (state == ST_IDLE) || (state == ST_FILL);
  assign out_valid = (state == ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;
  // Byte 0 of a word lands in bits [31:24], byte 3 in bits [7:0].
  assign lane_lsb  = {~idx[1:0], 3'b000};

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_INIT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      ST_INIT: next_state = ST_IDLE;
      ST_IDLE,
      ST_FILL: begin
        if (accept) begin
          next_state = in_last ? ST_HOLD : ST_FILL;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Word buffer, byte index, saturating length and truncation flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      k0         <= '0;
      k1         <= '0;
      k2         <= '0;
      idx        <= '0;
      key_length <= '0;
      trunc      <= 1'b0;
    end else if (handshake) begin
      k0         <= '0;
      k1         <= '0;
      k2         <= '0;
      idx        <= '0;
      key_length <= '0;
      trunc      <= 1'b0;
    end else if (accept) begin
      if (idx < 4'd12) begin
        case (idx[3:2])
          2'd0:    k0[lane_lsb +: 8] <= in_data;
          2'd1:    k1[lane_lsb +: 8] <= in_data;
          default: k2[lane_lsb +: 8] <= in_data;
        endcase
        idx <= idx + 4'd1;
      end else begin
        trunc <= 1'b1;
      end
      if (key_length != {LEN_W{1'b1}}) begin
        key_length <= key_length + 1'b1;
      end
    end
  end

`ifdef MEMKEY_STATS_EN
  // Handshake statistics: key count wraps, truncated-key count saturates.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stat_keys  <= '0;
      stat_trunc <= '0;
    end else if (handshake) begin
      stat_keys <= stat_keys + 32'd1;
      if (trunc && (stat_trunc != 16'hFFFF)) begin
        stat_trunc <= stat_trunc + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_memkey_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_memkey_packer                                           |
// | Description : Randomized self-checking bench for memkey_packer against a |
// |               byte-array reference model. Honours MEMKEY_STATS_EN.       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_memkey_packer;

  localparam int LEN_W = 8;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      k0, k1, k2;
  logic [LEN_W-1:0] key_length;
  logic             trunc;
`ifdef MEMKEY_STATS_EN
  logic [31:0]      stat_keys;
  logic [15:0]      stat_trunc;
`endif

  memkey_packer #(.LEN_W(LEN_W)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .k0         (k0),
    .k1         (k1),
    .k2         (k2),
    .key_length (key_length),
    .trunc      (trunc)
`ifdef MEMKEY_STATS_EN
    ,
    .stat_keys  (stat_keys),
    .stat_trunc (stat_trunc)
`endif
  );

  always #5 CLK = ~CLK;

  int  tests_run    = 0;
  int  tests_failed = 0;
  int  exp_keys     = 0;
  int  exp_trunc    = 0;
  byte unsigned cur_key[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_string(input string s);
    cur_key.delete();
    for (int i = 0; i < s.len(); i++) cur_key.push_back(s[i]);
  endtask

  task automatic load_random(input int n);
    cur_key.delete();
    for (int i = 0; i < n; i++) cur_key.push_back(8'($urandom_range(0, 255)));
  endtask

  // Drive cur_key byte by byte with random idle gaps; in_last only if finish.
  task automatic send_bytes(input bit finish);
    bit acc;
    int guard;
    for (int i = 0; i < cur_key.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));  // must be ignored without valid
        in_data  = 8'($urandom_range(0, 255));
        @(posedge CLK); #1;
      end
      in_valid = 1'b1;
      in_data  = cur_key[i];
      in_last  = finish && (i == cur_key.size() - 1);
      guard    = 0;
      acc      = 1'b0;
      while (!acc) begin
        @(negedge CLK);
        acc = in_ready;
        @(posedge CLK); #1;
        guard++;
        if (!acc && guard > 50) begin
          check("accept_timeout", 64'd1, 64'd0);
          in_valid = 1'b0;
          in_last  = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Send a full key, check the block against the model, stall, then hand off.
  task automatic run_key(input int hold_cycles);
    logic [31:0]      w[3];
    logic [LEN_W-1:0] e_len;
    logic             e_trunc;
    int               n;
    n = cur_key.size();
    w[0] = 0; w[1] = 0; w[2] = 0;
    for (int i = 0; i < n && i < 12; i++)
      w[i / 4] = w[i / 4] | (32'(cur_key[i]) << (24 - 8 * (i % 4)));
    e_len   = (n > (1 << LEN_W) - 1) ? LEN_W'((1 << LEN_W) - 1) : LEN_W'(n);
    e_trunc = (n > 12);

    send_bytes(1'b1);
    check("out_valid_latency", 64'(out_valid), 64'd1);
    check("k0", 64'(k0), 64'(w[0]));
    check("k1", 64'(k1), 64'(w[1]));
    check("k2", 64'(k2), 64'(w[2]));
    check("key_length", 64'(key_length), 64'(e_len));
    check("trunc", 64'(trunc), 64'(e_trunc));
    check("in_ready_hold", 64'(in_ready), 64'd0);

    out_ready = 1'b0;
    for (int c = 0; c < hold_cycles; c++) begin
      in_valid = 1'b1;                        // a byte waits during HOLD
      in_data  = 8'($urandom_range(0, 255));
      in_last  = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_block", {k0, k1[31:0]} ^ {32'(k2), 24'd0, 8'(key_length)},
            {w[0], w[1]} ^ {w[2], 24'd0, 8'(e_len)});
      check("stall_trunc", 64'(trunc), 64'(e_trunc));
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    exp_keys++;
    if (e_trunc && exp_trunc < 16'hFFFF) exp_trunc++;
    check("post_hs_out_valid", 64'(out_valid), 64'd0);
    check("post_hs_in_ready", 64'(in_ready), 64'd1);
`ifdef MEMKEY_STATS_EN
    check("stat_keys", 64'(stat_keys), 64'(exp_keys));
    check("stat_trunc", 64'(stat_trunc), 64'(exp_trunc));
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_k"}, 64'(k0) | 64'(k1) | 64'(k2), 64'd0);
    check({tag, "_len_trunc"}, 64'({trunc, key_length}), 64'd0);
`ifdef MEMKEY_STATS_EN
    check({tag, "_stats"}, 64'(stat_keys) | 64'(stat_trunc), 64'd0);
`endif
  endtask

  initial begin
    RST_N     = 1'b0;
    in_data   = 8'd0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    #2 RST_N = 1'b1;                  // release between edges
    #1 check("in_ready_pre_edge", 64'(in_ready), 64'd0);
    @(posedge CLK); #1;
    check("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Full 12-byte key with literal expectations.
    load_string("abcdefghijkl");
    run_key(1);
    // Short key and a one-byte key.
    load_string("abc");
    run_key(0);
    load_string("z");
    run_key(2);
    // Oversize keys: 20 bytes, then 300 bytes (length saturates).
    load_string("abcdefghijklmnopqrst");
    run_key(0);
    load_random(300);
    run_key(1);
    // Backpressure: five stall cycles with a byte waiting.
    load_random(7);
    run_key(5);

    // Reset mid-key after 5 bytes, asserted between edges.
    load_random(5);
    send_bytes(1'b0);
    #2 RST_N = 1'b0;
    #1 check_reset_outputs("midkey_reset");
    exp_keys  = 0;
    exp_trunc = 0;
    #1 RST_N = 1'b1;
    @(posedge CLK); #1;
    check("in_ready_after_midkey_reset", 64'(in_ready), 64'd1);
    load_string("xy");
    run_key(0);

    // Boundary lengths around the 12-byte buffer and the saturation point.
    load_random(11); run_key(0);
    load_random(12); run_key(1);
    load_random(13); run_key(0);
    load_random(255); run_key(0);
    load_random(256); run_key(0);

    // Random keys.
    for (int k = 0; k < 25; k++) begin
      load_random($urandom_range(1, 30));
      run_key($urandom_range(0, 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Literal spot checks of the worked examples, sampled when each block appears.
  initial begin
    @(posedge RST_N);
    wait (out_valid === 1'b1); #1;
    check("lit_abcd_k0", 64'(k0), 64'h61626364);
    check("lit_abcd_k2", 64'(k2), 64'h696A6B6C);
    wait (out_valid === 1'b0);
    wait (out_valid === 1'b1); #1;
    check("lit_abc_k0", 64'(k0), 64'h61626300);
    wait (out_valid === 1'b0);
    wait (out_valid === 1'b1); #1;
    check("lit_z_k0", 64'(k0), 64'h7A000000);
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
